data_mem_responder: RTL

Synthesizable responder for the pipeline's data-memory port: it accepts one read or write from the datapath, waits a configurable latency, then pulses `data_mem_resp` with read data. It backs the datapath's `data_mem_*` signals in simulation and FPGA builds. It replaces the always-ready magic memory so the pipeline can be exercised against multi-cycle responses.

---
 rtl/rv32i_types.sv | 15 +
 rtl/data_sram.sv | 30 +++
 rtl/data_mem_responder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types for the pipeline's memory-side blocks.
package rv32i_types;

  // Responder handshake: accept in IDLE, count down in BUSY, pulse resp in DONE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_resp_state_t;

  // Latency countdown width and the largest latency it can represent.
  localparam int unsigned MemCntBits    = 4;
  localparam int unsigned MemMaxLatency = (1 << MemCntBits) - 1;

endpackage

// File: rtl/data_sram.sv
// Single-port word array with per-byte write enables and no reset.
// Writes commit on the clock edge; the read port is a plain array lookup so
// the owner decides on which edge the data gets captured.
module data_sram #(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [3:0]           i_be,
  input  logic [ADDR_BITS-1:0] i_index,
  input  logic [31:0]          i_wdata,
  output logic [31:0]          o_rdata
);

  logic [31:0] r_mem [0:(1 << ADDR_BITS)-1];

  // Byte-lane write: only enabled lanes of the addressed word change.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) begin
          r_mem[i_index][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_index];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle responder for the datapath's data-memory port. One request is
// latched in IDLE, held for LATENCY cycles, then answered with a single
// data_mem_resp pulse. Writes commit on the edge leaving DONE.
module data_mem_responder
  import rv32i_types::*;
#(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_mem_read,
  input  logic        data_mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] data_mem_address,
  input  logic [31:0] data_mem_wdata,
  output logic [31:0] data_mem_rdata,
  output logic        data_mem_resp
);

  if (LATENCY < 1 || LATENCY > MemMaxLatency) begin : g_bad_latency
    $fatal(1, "data_mem_responder: LATENCY must be in 1..15");
  end

  localparam logic [MemCntBits-1:0] CntLoad = MemCntBits'(LATENCY - 1);

  mem_resp_state_t        r_state;
  mem_resp_state_t        w_state_next;
  logic [MemCntBits-1:0]  r_cnt;
  logic                   r_is_write;
  logic [ADDR_BITS-1:0]   r_index;
  logic [31:0]            r_wdata;
  logic [3:0]             r_be;
  logic [31:0]            r_rdata;

  logic                   w_req;
  logic                   w_sram_we;
  logic [31:0]            w_sram_rdata;
  logic [ADDR_BITS-1:0]   w_req_index;
  logic                   w_unused_addr;

  assign w_req       = data_mem_read | data_mem_write;
  assign w_req_index = data_mem_address[ADDR_BITS+1:2];
  // Byte offset and bits above the array are dropped, so addresses alias.
  assign w_unused_addr = ^{data_mem_address[31:ADDR_BITS+2], data_mem_address[1:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. With LATENCY=1 the counter loads as zero, so BUSY lasts
  // one cycle and resp still lands LATENCY cycles after acceptance.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_req) w_state_next = BUSY;
      BUSY:    if (r_cnt == '0) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs; the write commit is gated by rst so a reset in DONE drops it.
  always_comb begin
    data_mem_resp = (r_state == DONE);
    w_sram_we     = (r_state == DONE) && r_is_write && !rst;
  end

  // Request latches, latency counter and read-data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_is_write <= 1'b0;
      r_index    <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_rdata    <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            // Read and write together is treated as a write.
            r_is_write <= data_mem_write;
            r_index    <= w_req_index;
            r_wdata    <= data_mem_wdata;
            r_be       <= mem_byte_enable;
            r_cnt      <= CntLoad;
          end
        end
        BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!r_is_write) begin
            r_rdata <= w_sram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_mem_rdata = r_rdata;

  data_sram #(
    .ADDR_BITS (ADDR_BITS)
  ) u_sram (
    .clk     (clk),
    .i_we    (w_sram_we),
    .i_be    (r_be),
    .i_index (r_index),
    .i_wdata (r_wdata),
    .o_rdata (w_sram_rdata)
  );

endmodule
